// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_pkg : shared types and constants for the pipeline hazard
//                        controller (state encoding, register index width)
// Revision: 1.0
// ============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int REG_IDX_W = 4;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_SP = 4'd13;
  localparam reg_idx_t REG_LR = 4'd14;
  localparam reg_idx_t REG_PC = 4'd15;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl_if : pipeline-side bus of the hazard controller
// Revision: 1.0
// ============================================================================
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 16
) ();

  logic             fwd_en;
  reg_idx_t         id_src1;
  reg_idx_t         id_src2;
  logic             id_src1_vld;
  logic             id_src2_vld;
  reg_idx_t         exe_dest;
  logic             exe_wb_en;
  logic             exe_mem_read;
  reg_idx_t         mem_dest;
  logic             mem_wb_en;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;

  logic             pc_freeze;
  logic             if_id_freeze;
  logic             id_ex_freeze;
  logic             ex_mem_freeze;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             mem_wb_bubble;
  logic             mem_abort;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output fwd_en, id_src1, id_src2, id_src1_vld, id_src2_vld,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    input  pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_abort,
           mem_timeout, stall_cnt, flush_cnt
  );

  modport slave (
    input  fwd_en, id_src1, id_src2, id_src1_vld, id_src2_vld,
           exe_dest, exe_wb_en, exe_mem_read, mem_dest, mem_wb_en,
           branch_taken, mem_req, mem_ready,
    output pc_freeze, if_id_freeze, id_ex_freeze, ex_mem_freeze,
           if_id_flush, id_ex_flush, mem_wb_bubble, mem_abort,
           mem_timeout, stall_cnt, flush_cnt
  );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// hazard_detect : combinational RAW compare of ID sources against in-flight
//                 destinations; fwd_en narrows the check to load-use only
// Revision: 1.0
// ============================================================================
module hazard_detect
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic     fwd_en,
  input  reg_idx_t src1,
  input  reg_idx_t src2,
  input  logic     src1_vld,
  input  logic     src2_vld,
  input  reg_idx_t exe_dest,
  input  logic     exe_wb_en,
  input  logic     exe_mem_read,
  input  reg_idx_t mem_dest,
  input  logic     mem_wb_en,
  output logic     hazard
);

  logic w_src1_match;
  logic w_src2_match;

  // With forwarding only a load result is still unavailable to the next instruction
  function automatic logic dest_conflict(
    input logic     fwd,
    input reg_idx_t src,
    input reg_idx_t e_dest,
    input logic     e_wb,
    input logic     e_ld,
    input reg_idx_t m_dest,
    input logic     m_wb
  );
    if (fwd) begin
      return e_ld && (e_dest == src);
    end
    return (e_wb && (e_dest == src)) || (m_wb && (m_dest == src));
  endfunction

  always_comb begin
    w_src1_match = src1_vld &&
                   dest_conflict(fwd_en, src1, exe_dest, exe_wb_en,
                                 exe_mem_read, mem_dest, mem_wb_en);
    w_src2_match = src2_vld &&
                   dest_conflict(fwd_en, src2, exe_dest, exe_wb_en,
                                 exe_mem_read, mem_dest, mem_wb_en);
    hazard       = w_src1_match || w_src2_match;
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl : pipeline register sequencing - RAW stall, branch flush,
//                    MEM wait freeze with watchdog abort, perf counters
// Revision: 1.0
// ============================================================================
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 63
) (
  input  logic               clk,
  input  logic               rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [WAIT_W-1:0] w_cnt_base;
  logic              r_timeout;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;

  logic w_hazard;
  logic w_mem_wait;
  logic w_abort;
  logic w_pc_freeze;
  logic w_if_id_freeze;
  logic w_id_ex_freeze;
  logic w_ex_mem_freeze;
  logic w_if_id_flush;
  logic w_id_ex_flush;
  logic w_mem_wb_bubble;

  hazard_detect u_hazard_detect (
    .fwd_en       (bus.fwd_en),
    .src1         (bus.id_src1),
    .src2         (bus.id_src2),
    .src1_vld     (bus.id_src1_vld),
    .src2_vld     (bus.id_src2_vld),
    .exe_dest     (bus.exe_dest),
    .exe_wb_en    (bus.exe_wb_en),
    .exe_mem_read (bus.exe_mem_read),
    .mem_dest     (bus.mem_dest),
    .mem_wb_en    (bus.mem_wb_en),
    .hazard       (w_hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Priority mux: memory wait beats branch flush beats RAW stall
  always_comb begin
    w_pc_freeze     = 1'b0;
    w_if_id_freeze  = 1'b0;
    w_id_ex_freeze  = 1'b0;
    w_ex_mem_freeze = 1'b0;
    w_if_id_flush   = 1'b0;
    w_id_ex_flush   = 1'b0;
    w_mem_wb_bubble = 1'b0;
    w_abort         = 1'b0;
    w_state_nxt     = ST_RUN;
    w_wait_cnt_nxt  = '0;
    w_cnt_base      = (r_state == ST_MEM_WAIT) ? r_wait_cnt : '0;
    w_mem_wait      = bus.mem_req && !bus.mem_ready;

    if (rst) begin
      w_state_nxt = ST_RUN;
    end else if (w_mem_wait && (w_cnt_base >= WAIT_W'(MAX_WAIT - 1))) begin
      w_abort         = 1'b1;
      w_mem_wb_bubble = 1'b1;
    end else if (w_mem_wait) begin
      w_pc_freeze     = 1'b1;
      w_if_id_freeze  = 1'b1;
      w_id_ex_freeze  = 1'b1;
      w_ex_mem_freeze = 1'b1;
      w_mem_wb_bubble = 1'b1;
      w_state_nxt     = ST_MEM_WAIT;
      w_wait_cnt_nxt  = w_cnt_base + WAIT_W'(1);
    end else if (bus.branch_taken) begin
      w_if_id_flush = 1'b1;
      w_id_ex_flush = 1'b1;
    end else if (w_hazard) begin
      w_pc_freeze    = 1'b1;
      w_if_id_freeze = 1'b1;
      w_id_ex_flush  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt  <= '0;
      r_timeout   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wait_cnt <= w_wait_cnt_nxt;
      r_timeout  <= r_timeout | w_abort;
      if (w_pc_freeze && (r_stall_cnt != {CNT_W{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_if_id_flush && (r_flush_cnt != {CNT_W{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.pc_freeze     = w_pc_freeze;
  assign bus.if_id_freeze  = w_if_id_freeze;
  assign bus.id_ex_freeze  = w_id_ex_freeze;
  assign bus.ex_mem_freeze = w_ex_mem_freeze;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_flush   = w_id_ex_flush;
  assign bus.mem_wb_bubble = w_mem_wb_bubble;
  assign bus.mem_abort     = w_abort;
  assign bus.mem_timeout   = r_timeout;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl : two instances (wide counters / short watchdog) driven
//                       by shared stimulus and checked against a rule model
// Revision: 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  localparam int CNT_A  = 16;
  localparam int WAIT_A = 5;
  localparam int CNT_B  = 2;
  localparam int WAIT_B = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_A)) bus_a ();
  pipe_hazard_ctrl_if #(.CNT_W(CNT_B)) bus_b ();

  pipe_hazard_ctrl #(.CNT_W(CNT_A), .MAX_WAIT(WAIT_A)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  pipe_hazard_ctrl #(.CNT_W(CNT_B), .MAX_WAIT(WAIT_B)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  assign bus_b.fwd_en       = bus_a.fwd_en;
  assign bus_b.id_src1      = bus_a.id_src1;
  assign bus_b.id_src2      = bus_a.id_src2;
  assign bus_b.id_src1_vld  = bus_a.id_src1_vld;
  assign bus_b.id_src2_vld  = bus_a.id_src2_vld;
  assign bus_b.exe_dest     = bus_a.exe_dest;
  assign bus_b.exe_wb_en    = bus_a.exe_wb_en;
  assign bus_b.exe_mem_read = bus_a.exe_mem_read;
  assign bus_b.mem_dest     = bus_a.mem_dest;
  assign bus_b.mem_wb_en    = bus_a.mem_wb_en;
  assign bus_b.branch_taken = bus_a.branch_taken;
  assign bus_b.mem_req      = bus_a.mem_req;
  assign bus_b.mem_ready    = bus_a.mem_ready;

  // {pc, if_id, id_ex, ex_mem freezes, if_id flush, id_ex flush, bubble, abort}
  logic [7:0] got_a;
  logic [7:0] got_b;
  assign got_a = {bus_a.pc_freeze, bus_a.if_id_freeze, bus_a.id_ex_freeze,
                  bus_a.ex_mem_freeze, bus_a.if_id_flush, bus_a.id_ex_flush,
                  bus_a.mem_wb_bubble, bus_a.mem_abort};
  assign got_b = {bus_b.pc_freeze, bus_b.if_id_freeze, bus_b.id_ex_freeze,
                  bus_b.ex_mem_freeze, bus_b.if_id_flush, bus_b.id_ex_flush,
                  bus_b.mem_wb_bubble, bus_b.mem_abort};

  int n_chk  = 0;
  int n_fail = 0;

  // Model state per instance: consecutive wait cycles seen, counters, sticky flag
  int wmax [2] = '{WAIT_A, WAIT_B};
  int cmax [2] = '{(1 << CNT_A) - 1, (1 << CNT_B) - 1};
  int m_wait  [2];
  int m_stall [2];
  int m_flush [2];
  int m_to    [2];

  task automatic chk(input string name, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic bit unresolved(input logic [3:0] r);
    if (bus_a.fwd_en) return bus_a.exe_mem_read && (bus_a.exe_dest == r);
    return (bus_a.exe_wb_en && (bus_a.exe_dest == r)) ||
           (bus_a.mem_wb_en && (bus_a.mem_dest == r));
  endfunction

  function automatic logic [7:0] exp_ctrl(input int k);
    bit mw, hz;
    mw = bus_a.mem_req && !bus_a.mem_ready;
    hz = (bus_a.id_src1_vld && unresolved(bus_a.id_src1)) ||
         (bus_a.id_src2_vld && unresolved(bus_a.id_src2));
    if (rst)                               return 8'b0000_0000;
    if (mw && (m_wait[k] + 1 >= wmax[k]))  return 8'b0000_0011;
    if (mw)                                return 8'b1111_0010;
    if (bus_a.branch_taken)                return 8'b0000_1100;
    if (hz)                                return 8'b1100_0100;
    return 8'b0000_0000;
  endfunction

  // Check one cycle (inputs already applied at negedge), then advance the model
  task automatic cycle();
    logic [7:0] e [2];
    bit mw;
    #2;
    mw = bus_a.mem_req && !bus_a.mem_ready;
    for (int k = 0; k < 2; k++) e[k] = exp_ctrl(k);
    chk("ctrl_a",    got_a,             e[0]);
    chk("ctrl_b",    got_b,             e[1]);
    chk("timeout_a", bus_a.mem_timeout, m_to[0]);
    chk("timeout_b", bus_b.mem_timeout, m_to[1]);
    chk("stall_a",   bus_a.stall_cnt,   m_stall[0]);
    chk("stall_b",   bus_b.stall_cnt,   m_stall[1]);
    chk("flush_a",   bus_a.flush_cnt,   m_flush[0]);
    chk("flush_b",   bus_b.flush_cnt,   m_flush[1]);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_to[k] = 0;
      end else begin
        if (e[k][7]) m_stall[k] = (m_stall[k] < cmax[k]) ? m_stall[k] + 1 : cmax[k];
        if (e[k][3]) m_flush[k] = (m_flush[k] < cmax[k]) ? m_flush[k] + 1 : cmax[k];
        if (e[k][0]) m_to[k] = 1;
        m_wait[k] = (mw && !e[k][0]) ? m_wait[k] + 1 : 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    bus_a.fwd_en = 1'b0;       bus_a.id_src1 = 4'd0;     bus_a.id_src2 = 4'd0;
    bus_a.id_src1_vld = 1'b0;  bus_a.id_src2_vld = 1'b0; bus_a.exe_dest = 4'd0;
    bus_a.exe_wb_en = 1'b0;    bus_a.exe_mem_read = 1'b0; bus_a.mem_dest = 4'd0;
    bus_a.mem_wb_en = 1'b0;    bus_a.branch_taken = 1'b0;
    bus_a.mem_req = 1'b0;      bus_a.mem_ready = 1'b0;
  endtask

  task automatic rand_inputs();
    bit hold;
    hold = bus_a.mem_req && !bus_a.mem_ready && ($urandom_range(0, 9) != 0);
    bus_a.fwd_en       = 1'($urandom_range(0, 1));
    bus_a.id_src1      = 4'($urandom_range(0, 3));
    bus_a.id_src2      = 4'($urandom_range(0, 3));
    bus_a.id_src1_vld  = 1'($urandom_range(0, 1));
    bus_a.id_src2_vld  = 1'($urandom_range(0, 1));
    bus_a.exe_dest     = 4'($urandom_range(0, 3));
    bus_a.exe_wb_en    = 1'($urandom_range(0, 1));
    bus_a.exe_mem_read = 1'($urandom_range(0, 1));
    bus_a.mem_dest     = 4'($urandom_range(0, 3));
    bus_a.mem_wb_en    = 1'($urandom_range(0, 1));
    bus_a.branch_taken = ($urandom_range(0, 4) == 0);
    bus_a.mem_req      = hold || ($urandom_range(0, 9) < 3);
    bus_a.mem_ready    = ($urandom_range(0, 3) == 0);
    rst                = ($urandom_range(0, 199) == 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_wait[k] = 0; m_stall[k] = 0; m_flush[k] = 0; m_to[k] = 0;
    end
    rst = 1'b1;
    idle_inputs();
    bus_a.mem_req = 1'b1;
    @(negedge clk);
    #1 chk("rst_forces_zero", got_a, 8'h00);
    cycle();
    cycle();
    rst = 1'b0;
    bus_a.mem_req = 1'b0;
    cycle();
    chk("rst_stall_cnt", bus_a.stall_cnt, 0);

    // RAW without forwarding
    bus_a.id_src1 = 4'd3; bus_a.id_src1_vld = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    #1 chk("raw_stall", {bus_a.pc_freeze, bus_a.if_id_freeze, bus_a.id_ex_flush, bus_a.ex_mem_freeze}, 4'b1110);
    cycle();
    chk("raw_stall_cnt", bus_a.stall_cnt, 1);

    // Forwarding: only load-use stalls
    bus_a.fwd_en = 1'b1;
    #1 chk("fwd_no_stall", bus_a.pc_freeze, 0);
    cycle();
    bus_a.exe_mem_read = 1'b1;
    #1 chk("load_use_stall", bus_a.pc_freeze, 1);
    cycle();
    bus_a.exe_mem_read = 1'b0;
    #1 chk("load_use_clean", bus_a.pc_freeze, 0);
    cycle();

    // Branch overrides hazard
    bus_a.fwd_en = 1'b0; bus_a.branch_taken = 1'b1;
    #1 chk("branch_flush", {bus_a.if_id_flush, bus_a.id_ex_flush, bus_a.pc_freeze}, 3'b110);
    cycle();
    chk("branch_flush_cnt", bus_a.flush_cnt, 1);
    idle_inputs();

    // Four wait cycles with a branch held; flush lands on the ready cycle
    bus_a.mem_req = 1'b1; bus_a.branch_taken = 1'b1;
    #1 chk("wait_freeze", got_a, 8'b1111_0010);
    for (int i = 0; i < 4; i++) cycle();
    bus_a.mem_ready = 1'b1;
    #1 chk("release_flush", {bus_a.if_id_flush, bus_a.pc_freeze}, 2'b10);
    cycle();
    idle_inputs();
    cycle();

    // Watchdog on the short instance
    bus_a.mem_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("abort_pulse_b", bus_b.mem_abort, (i == 2) ? 1 : 0);
      cycle();
    end
    chk("timeout_set_b", bus_b.mem_timeout, 1);
    chk("timeout_clr_a", bus_a.mem_timeout, 0);
    idle_inputs();
    cycle();
    chk("timeout_sticky_b", bus_b.mem_timeout, 1);

    // Six hazard cycles saturate the 2-bit counter
    bus_a.id_src1 = 4'd3; bus_a.id_src1_vld = 1'b1;
    bus_a.exe_dest = 4'd3; bus_a.exe_wb_en = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    chk("stall_sat_b", bus_b.stall_cnt, 3);
    idle_inputs();

    // Reset in the middle of a memory wait
    bus_a.mem_req = 1'b1;
    cycle();
    rst = 1'b1;
    #1 chk("rst_in_wait", got_a, 8'h00);
    cycle();
    rst = 1'b0; bus_a.mem_req = 1'b0;
    #1 chk("post_rst_timeout_b", bus_b.mem_timeout, 0);
    chk("post_rst_stall_a", bus_a.stall_cnt, 0);
    cycle();

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
